unidade_controle_multiciclo: RTL
================================

// Module: unidade_controle_multiciclo
// PURPOSE
//   Multi-cycle control FSM for the RISC-V datapath. Owns the PC, drives the 4-bit estado bus
//   that the instruction memory samples (fetch on estado==4'b0000), and issues Moore-style
//   strobes to the register file, ALU and data memory. Supports lw, sw, R-type, addi-class
//   OP-IMM and beq. Stops on an all-zero word, an end-of-program PC or an illegal opcode.
// PARAMETERS
//   PC_W       32  width of pc / pc_atual (word index into instruction memory)
//   NUM_INSTR  9   instruction memory depth; fetch with pc >= NUM_INSTR halts
// PORTS
//   clk        in   1     system clock, rising edge
//   rst        in   1     asynchronous, active-high reset
//   opcode     in   7     instrucao[6:0]; valid from DECODE onward
//   funct3     in   3     instrucao[14:12]
//   zero       in   1     ALU zero flag; sampled in BRANCH
//   imm_b      in   13    B-type byte offset, signed; sampled in BRANCH
//   estado     out  4     current state code, to instruction memory and datapath
//   pc         out  PC_W  address presented to instruction memory
//   pc_atual   out  PC_W  PC of the instruction now executing
//   reg_write  out  1     register-file write enable
//   mem_read   out  1     data-memory read strobe
//   mem_write  out  1     data-memory write strobe
//   alu_src    out  1     0 = rs2, 1 = immediate
//   alu_op     out  2     00 add, 01 sub, 10 R-type funct decode, 11 I-type funct3 decode
//   mem_to_reg out  1     writeback source: 1 = memory, 0 = ALU
//   halted     out  1     sticky; set on HALT entry
//   illegal    out  1     sticky; set on illegal decode
// BEHAVIOUR
//   Reset (async, any time, including mid-instruction): estado=FETCH, pc=0, pc_atual=0,
//     halted=0, illegal=0, all strobes 0. Hold rst high across >=1 clk edge so that
//     instruction memory also reloads.
//   States: 0000 FETCH, 0001 DECODE, 0010 MEM_ADDR, 0011 MEM_READ, 0100 WB_MEM, 0101 MEM_WRITE,
//     0110 EXEC_R, 0111 WB_ALU, 1000 EXEC_I, 1010 BRANCH, 1110 TRAP, 1111 HALT.
//   FETCH: if pc >= NUM_INSTR -> HALT, pc unchanged. Else pc_atual<=pc, pc<=pc+1 -> DECODE.
//     Instruction memory latches instrucoes[pc] on this same edge.
//   DECODE on opcode: 0000011/0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I;
//     1100011 with funct3==000 -> BRANCH; 0000000 -> HALT; anything else -> TRAP.
//   MEM_ADDR: alu_src=1, alu_op=00. Next MEM_READ for lw, MEM_WRITE for sw (opcode re-read).
//   MEM_READ: mem_read=1 -> WB_MEM. WB_MEM: reg_write=1, mem_to_reg=1 -> FETCH.
//   MEM_WRITE: mem_write=1 -> FETCH.
//   EXEC_R: alu_src=0, alu_op=10 -> WB_ALU. EXEC_I: alu_src=1, alu_op=11 -> WB_ALU.
//   WB_ALU: reg_write=1, mem_to_reg=0 -> FETCH.
//   BRANCH: alu_src=0, alu_op=01. If zero: pc <= pc_atual + sext(imm_b[12:2]), mod 2^PC_W.
//     Otherwise pc keeps pc_atual+1. -> FETCH.
//   TRAP: illegal<=1 on entry, then -> HALT. HALT: halted=1, absorbing until rst.
//   All outputs are decoded from the state register only, as pure Moore outputs.
//   Outside the states named above, every strobe is 0.
//   Latency in cycles, FETCH through last state: lw 5, sw 4, R 4, addi 4, beq 3.
//   Unused codes 1001, 1011, 1100, 1101 -> TRAP.
// TESTING
//   T1: rst pulse, then lw word 0x0000A003 -> estado 0,1,2,3,4,0; mem_read only in 0011,
//       reg_write+mem_to_reg only in 0100, pc 0->1.
//   T2: 9-word program ending 0x00000000 -> halted=1 after word 8 decodes, pc=9, illegal=0.
//   T3: beq x0,x0,+8 (0x00000463) at pc 6, zero=1 -> next FETCH pc=8.
//       Same instruction with zero=0 -> pc=7.
//   T4: opcode 1111111 in DECODE -> TRAP then HALT; illegal=1, halted=1, no strobes afterwards.
//   T5: assert rst asynchronously during MEM_WRITE -> mem_write drops without a clk edge;
//       estado=0000, pc=0.
//   T6: NUM_INSTR=4 with no halt word -> FETCH with pc=4 goes to HALT; no DECODE occurs.

Source files
------------

// File: rtl/unidade_controle_multiciclo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | unidade_controle_multiciclo: multi-cycle RISC-V control FSM, owns the PC |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module unidade_controle_multiciclo #(
  parameter int PC_W      = 32,
  parameter int NUM_INSTR = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            zero,
  input  logic [12:0]     imm_b,
  output logic [3:0]      estado,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_atual,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            alu_src,
  output logic [1:0]      alu_op,
  output logic            mem_to_reg,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'b0000,
    S_DECODE    = 4'b0001,
    S_MEM_ADDR  = 4'b0010,
    S_MEM_READ  = 4'b0011,
    S_WB_MEM    = 4'b0100,
    S_MEM_WRITE = 4'b0101,
    S_EXEC_R    = 4'b0110,
    S_WB_ALU    = 4'b0111,
    S_EXEC_I    = 4'b1000,
    S_BRANCH    = 4'b1010,
    S_TRAP      = 4'b1110,
    S_HALT      = 4'b1111
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_HALT   = 7'b0000000;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_atual_q;
  logic            illegal_q;
  logic [PC_W-1:0] br_off;
  logic            unused_imm;

  // imm_b is a byte offset; pc counts words, so the two low bits drop out.
  assign br_off     = {{(PC_W-11){imm_b[12]}}, imm_b[12:2]};
  assign unused_imm = ^imm_b[1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = (pc_q >= PC_W'(NUM_INSTR)) ? S_HALT : S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BRANCH:    state_d = (funct3 == 3'b000) ? S_BRANCH : S_TRAP;
          OP_HALT:      state_d = S_HALT;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = S_WB_MEM;
      S_WB_MEM:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = S_FETCH;
      S_EXEC_R:    state_d = S_WB_ALU;
      S_EXEC_I:    state_d = S_WB_ALU;
      S_WB_ALU:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_TRAP:      state_d = S_HALT;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      pc_atual_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && state_d == S_DECODE) begin
        pc_atual_q <= pc_q;
        pc_q       <= pc_q + PC_W'(1);
      end
      if (state_q == S_BRANCH && zero) begin
        pc_q <= pc_atual_q + br_off;
      end
      if (state_d == S_TRAP) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Moore decode straight off the state register, so an async reset clears strobes at once.
  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    case (state_q)
      S_MEM_ADDR:  alu_src = 1'b1;
      S_MEM_READ:  mem_read = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: mem_write = 1'b1;
      S_EXEC_R:    alu_op = 2'b10;
      S_EXEC_I: begin
        alu_src = 1'b1;
        alu_op  = 2'b11;
      end
      S_WB_ALU:    reg_write = 1'b1;
      S_BRANCH:    alu_op = 2'b01;
      default:     ;
    endcase
  end

  assign estado   = state_q;
  assign pc       = pc_q;
  assign pc_atual = pc_atual_q;
  assign halted   = (state_q == S_HALT);
  assign illegal  = illegal_q;

endmodule
`default_nettype wire
